// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX boundary register. Decodes RV32I R/I-type ALU
// instructions into alu_op/operand1/operand2 and holds them for the execute
// stage behind a valid/ready handshake with stall and flush.
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int OPW  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  alu_op,
  output logic [XLEN-1:0] operand1,
  output logic [XLEN-1:0] operand2,
  output logic [4:0]      rd,
  output logic            reg_write,
  output logic            illegal
);

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_AND  = OPW'(2);
  localparam logic [OPW-1:0] OP_OR   = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
  localparam logic [OPW-1:0] OP_ZERO = OPW'(7);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic            unused_rs1_field;

  assign opcode           = instr[6:0];
  assign funct3           = instr[14:12];
  assign funct7           = instr[31:25];
  assign imm_i            = {{(XLEN-12){instr[31]}}, instr[31:20]};
  // rs1 index is resolved by the register file upstream; only its data is used here.
  assign unused_rs1_field = ^instr[19:15];

  logic [OPW-1:0]  dec_op;
  logic            dec_legal;
  logic [XLEN-1:0] dec_op2;

  // Decode the incoming instruction into ALU controls.
  always_comb begin
    dec_op    = OP_ZERO;
    dec_legal = 1'b0;
    dec_op2   = rs2_data;
    case (opcode)
      OPC_R: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: begin dec_op = OP_ADD; dec_legal = 1'b1; end
            3'b111: begin dec_op = OP_AND; dec_legal = 1'b1; end
            3'b110: begin dec_op = OP_OR;  dec_legal = 1'b1; end
            3'b100: begin dec_op = OP_XOR; dec_legal = 1'b1; end
            default: ;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_op    = OP_SUB;
          dec_legal = 1'b1;
        end
      end
      OPC_I: begin
        dec_op2 = imm_i;
        case (funct3)
          3'b000: begin dec_op = OP_ADD; dec_legal = 1'b1; end
          3'b111: begin dec_op = OP_AND; dec_legal = 1'b1; end
          3'b110: begin dec_op = OP_OR;  dec_legal = 1'b1; end
          3'b100: begin dec_op = OP_XOR; dec_legal = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  logic            out_valid_q, out_valid_d;
  logic [OPW-1:0]  alu_op_q, alu_op_d;
  logic [XLEN-1:0] operand1_q, operand1_d;
  logic [XLEN-1:0] operand2_q, operand2_d;
  logic [4:0]      rd_q, rd_d;
  logic            reg_write_q, reg_write_d;
  logic            illegal_q, illegal_d;
  logic            load;

  assign in_ready = (!out_valid_q || out_ready) && !flush;
  assign load     = in_valid && in_ready;

  // Next-state: flush kills, load captures, consume drains; data holds otherwise.
  always_comb begin
    out_valid_d = out_valid_q;
    alu_op_d    = alu_op_q;
    operand1_d  = operand1_q;
    operand2_d  = operand2_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    illegal_d   = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      out_valid_d = 1'b1;
      alu_op_d    = dec_op;
      operand1_d  = rs1_data;
      operand2_d  = dec_op2;
      rd_d        = instr[11:7];
      reg_write_d = dec_legal && (instr[11:7] != 5'd0);
      illegal_d   = !dec_legal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Pipeline register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_op_q    <= OP_ZERO;
      operand1_q  <= '0;
      operand2_q  <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_op_q    <= alu_op_d;
      operand1_q  <= operand1_d;
      operand2_q  <= operand2_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_op    = alu_op_q;
  assign operand1  = operand1_q;
  assign operand2  = operand2_q;
  assign rd        = rd_q;
  assign reg_write = reg_write_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed decode table, hand-written handshake
// sequences, and randomized traffic against a behavioural model.
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  alu_op;
  logic [31:0] operand1;
  logic [31:0] operand2;
  logic [4:0]  rd;
  logic        reg_write;
  logic        illegal;

  alu_issue_stage #(.XLEN(32), .OPW(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .operand1(operand1), .operand2(operand2),
    .rd(rd), .reg_write(reg_write), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  op;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } vec_t;

  int unsigned passed = 0;
  int unsigned total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_entry(input string tag, input exp_t e);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".alu_op"},    32'(alu_op),    32'(e.op));
    chk({tag, ".operand1"},  operand1,       e.op1);
    if (!e.ill) chk({tag, ".operand2"}, operand2, e.op2);
    chk({tag, ".rd"},        32'(rd),        32'(e.rd));
    chk({tag, ".reg_write"}, 32'(reg_write), 32'(e.rw));
    chk({tag, ".illegal"},   32'(illegal),   32'(e.ill));
  endtask

  // Reference decode from the instruction-set rules, using a funct3 lookup table.
  function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] r1,
                                      input logic [31:0] r2);
    exp_t        e;
    int unsigned f3tab [8] = '{0, 7, 7, 7, 4, 7, 3, 2};
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    int          s;
    opc = i[6:0];
    f7  = i[31:25];
    f3  = i[14:12];
    s   = int'(i[31:20]);
    if (s >= 2048) s = s - 4096;
    e.op  = 3'd7;
    e.op1 = r1;
    e.op2 = r2;
    e.rd  = i[11:7];
    if (opc == 7'h33) begin
      if (f7 == 7'h00) e.op = 3'(f3tab[f3]);
      else if (f7 == 7'h20 && f3 == 3'd0) e.op = 3'd1;
    end else if (opc == 7'h13) begin
      e.op2 = 32'(s);
      e.op  = 3'(f3tab[f3]);
    end
    e.ill = (e.op == 3'd7);
    e.rw  = !e.ill && (e.rd != 5'd0);
    return e;
  endfunction

  function automatic exp_t from_vec(input vec_t v);
    exp_t e;
    e.op = v.op; e.op1 = v.rs1; e.op2 = v.op2; e.rd = v.rd; e.rw = v.rw; e.ill = v.ill;
    return e;
  endfunction

  vec_t vecs [$];
  exp_t ea, eb;
  logic        mv;
  exp_t        me;
  logic        exp_ready;
  logic [31:0] r;

  initial begin
    // instr, rs1, rs2, alu_op, operand2, rd, reg_write, illegal
    vecs.push_back('{32'h002081B3, 32'd5,        32'd7,        3'd0, 32'd7,        5'd3, 1'b1, 1'b0}); // add x3
    vecs.push_back('{32'h40208233, 32'd10,       32'd3,        3'd1, 32'd3,        5'd4, 1'b1, 1'b0}); // sub x4
    vecs.push_back('{32'hFFF0C093, 32'h12345678, 32'h0,        3'd4, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0}); // xori -1
    vecs.push_back('{32'h00000033, 32'd9,        32'd11,       3'd0, 32'd11,       5'd0, 1'b0, 1'b0}); // add x0
    vecs.push_back('{32'h0020C0B3, 32'hF0F0F0F0, 32'h0FF00FF0, 3'd4, 32'h0FF00FF0, 5'd1, 1'b1, 1'b0}); // xor
    vecs.push_back('{32'h00209033, 32'd1,        32'd2,        3'd7, 32'd0,        5'd0, 1'b0, 1'b1}); // sll
    vecs.push_back('{32'h00000000, 32'd4,        32'd6,        3'd7, 32'd0,        5'd0, 1'b0, 1'b1}); // zero
    vecs.push_back('{32'h80010293, 32'd100,      32'd0,        3'd0, 32'hFFFFF800, 5'd5, 1'b1, 1'b0}); // addi 0x800
    vecs.push_back('{32'h7FF07313, 32'hFFFF,     32'd0,        3'd2, 32'h000007FF, 5'd6, 1'b1, 1'b0}); // andi 0x7FF
    vecs.push_back('{32'h40006393, 32'd3,        32'd0,        3'd3, 32'h00000400, 5'd7, 1'b1, 1'b0}); // ori, funct7 ignored
    vecs.push_back('{32'h400063B3, 32'd3,        32'd5,        3'd7, 32'd0,        5'd7, 1'b0, 1'b1}); // R or with f7=0x20
    vecs.push_back('{32'h12345037, 32'd3,        32'd5,        3'd7, 32'd0,        5'd0, 1'b0, 1'b1}); // lui
    vecs.push_back('{32'h00007433, 32'hAAAA5555, 32'h0000FFFF, 3'd2, 32'h0000FFFF, 5'd8, 1'b1, 1'b0}); // and x8

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; rs1_data = '0; rs2_data = '0;
    #12;
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.alu_op",    32'(alu_op),    32'd7);
    chk("reset.operand1",  operand1,       32'd0);
    chk("reset.operand2",  operand2,       32'd0);
    chk("reset.rd",        32'(rd),        32'd0);
    chk("reset.reg_write", 32'(reg_write), 32'd0);
    chk("reset.illegal",   32'(illegal),   32'd0);
    chk("reset.in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;
    tick();

    // Back-to-back decode table with out_ready held high.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    foreach (vecs[k]) begin
      instr = vecs[k].instr; rs1_data = vecs[k].rs1; rs2_data = vecs[k].rs2;
      tick();
      chk_entry($sformatf("vec%0d", k), from_vec(vecs[k]));
    end

    // Drain: consume without new input.
    in_valid = 1'b0;
    tick();
    chk("drain.out_valid", 32'(out_valid), 32'd0);

    // Stall: entry A held three cycles while B waits, then B loads as A retires.
    out_ready = 1'b0; in_valid = 1'b1;
    instr = 32'h002081B3; rs1_data = 32'd21; rs2_data = 32'd22;
    ea = ref_decode(instr, rs1_data, rs2_data);
    tick();
    chk_entry("stall.A", ea);
    instr = 32'h40208233; rs1_data = 32'd31; rs2_data = 32'd32;
    eb = ref_decode(instr, rs1_data, rs2_data);
    for (int unsigned c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d.in_ready", c), 32'(in_ready), 32'd0);
      tick();
      chk_entry($sformatf("stall%0d.hold", c), ea);
    end
    out_ready = 1'b1;
    #1;
    chk("stall.release.in_ready", 32'(in_ready), 32'd1);
    tick();
    chk_entry("stall.B", eb);

    // Flush while stalled with a pending input: entry dropped, input not captured.
    out_ready = 1'b0; flush = 1'b1;
    instr = 32'h0020C0B3; rs1_data = 32'd1; rs2_data = 32'd2;
    #1;
    chk("flush.in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("flush.out_valid", 32'(out_valid), 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("flush.no_capture", 32'(out_valid), 32'd0);

    // Asynchronous reset between edges while an entry is held.
    in_valid = 1'b1; out_ready = 1'b0;
    instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7;
    tick();
    chk("areset.pre.out_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset.out_valid", 32'(out_valid), 32'd0);
    chk("areset.alu_op",    32'(alu_op),    32'd7);
    chk("areset.operand1",  operand1,       32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("areset.after.out_valid", 32'(out_valid), 32'd0);

    // Randomized traffic against the model.
    mv = 1'b0;
    me = ref_decode(32'h0, 32'h0, 32'h0);
    for (int unsigned n = 0; n < 400; n++) begin
      r = $urandom;
      case ($urandom_range(0, 3))
        0: begin r[6:0] = 7'h33; r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
        1: r[6:0] = 7'h13;
        2: r[6:0] = 7'h33;
        default: ;
      endcase
      instr     = r;
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 7) == 0);
      #1;
      exp_ready = (!mv || out_ready) && !flush;
      chk($sformatf("rnd%0d.in_ready", n), 32'(in_ready), 32'(exp_ready));
      if (flush) mv = 1'b0;
      else if (in_valid && exp_ready) begin
        mv = 1'b1;
        me = ref_decode(instr, rs1_data, rs2_data);
      end else if (out_ready) mv = 1'b0;
      tick();
      if (mv) chk_entry($sformatf("rnd%0d", n), me);
      else chk($sformatf("rnd%0d.out_valid", n), 32'(out_valid), 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete (got running, expected finished)");
    $fatal(1);
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX boundary register that decodes a 32-bit RV32I instruction into ALU-facing controls: alu_op, operand1 and operand2.
- Registers those controls for the combinational ALU downstream, which uses alu_op encoding 0=add, 1=sub, 2=and, 3=or, 4=xor, 7=zero-output.
- Upstream is the fetch/decode stage; downstream is the execute stage.
- Uses a valid/ready handshake with stall and flush support.

Parameters:
- XLEN, 32, operand/data width.
- OPW, 3, alu_op width; must equal the ALU opcode width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous pipeline kill; drops the held entry and any incoming one.
- in_valid  input  1  upstream presents instr/rs1_data/rs2_data.
- in_ready  output  1  stage can accept this cycle.
- instr  input  32  raw instruction.
- rs1_data  input  XLEN  register-file read port 1.
- rs2_data  input  XLEN  register-file read port 2.
- out_valid  output  1  registered entry valid for execute.
- out_ready  input  1  execute consumes the entry this cycle.
- alu_op  output  OPW  ALU operation code.
- operand1  output  XLEN  ALU operand 1.
- operand2  output  XLEN  ALU operand 2 (rs2_data or immediate).
- rd  output  5  destination register index.
- reg_write  output  1  writeback enable.
- illegal  output  1  instruction not supported by this ALU.

Behaviour:
- Reset (rst_n=0, async):
  - out_valid=0, alu_op=7, operand1=0, operand2=0, rd=0, reg_write=0, illegal=0.
  - Reset mid-transfer discards the entry; the first capture is on the first rising edge after deassertion.
- in_ready is combinational: (!out_valid || out_ready) && !flush.
- Capture (load = in_valid && in_ready): on the rising edge, register the decoded fields and set out_valid=1.
- Latency: 1 cycle from accepted input to out_valid.
- Supports back-to-back transfers at 1 per cycle while out_ready=1.
- Stall: out_valid=1 && out_ready=0 means all outputs hold bit-stable and in_ready=0.
- Drain: out_ready=1 && !load clears out_valid to 0. Data outputs may hold stale values.
- Flush has priority over everything except reset. Next edge: out_valid=0 and no capture. Data outputs hold.
- R-type decode (opcode 0110011), keyed on funct7/funct3:
  - 0000000/000 -> alu_op=0
  - 0100000/000 -> alu_op=1
  - 0000000/111 -> alu_op=2
  - 0000000/110 -> alu_op=3
  - 0000000/100 -> alu_op=4
  - operand2=rs2_data.
- I-type decode (opcode 0010011):
  - funct3 000 -> alu_op=0; 111 -> 2; 110 -> 3; 100 -> 4.
  - operand2 = instr[31:20] sign-extended to XLEN.
  - funct7 is ignored for these encodings.
- operand1 = rs1_data for all decodes.
- rd = instr[11:7].
- reg_write = decoded-legal && rd!=0.
- Anything else, including other opcodes, other funct3/funct7 combinations, and instr=0: alu_op=7, illegal=1, reg_write=0. operand1/operand2 are still captured; the entry still flows through the handshake.
- Immediate arithmetic: the full 12-bit value is sign-extended. 0x800 -> 0xFFFFF800; 0x7FF -> 0x000007FF.
- Simultaneous events:
  - out_ready=1 with in_valid=1 and no flush: the held entry retires and the new one loads on the same edge; out_valid stays 1.
  - flush=1 with in_valid=1: input is dropped (in_ready=0).
- No combinational path from in_valid to out_*. The only combinational outputs are in_ready from out_valid, out_ready and flush.

Test Plan:
- Reset, then in_valid=1, instr=0x002081B3 (add x3,x1,x2), rs1=5, rs2=7 -> next cycle: out_valid=1, alu_op=0, operand1=5, operand2=7, rd=3, reg_write=1, illegal=0.
- instr=0x40208233 (sub x4), then 0xFFF0C093 (xori x1,x1,-1) back-to-back with out_ready=1 -> alu_op=1 then 4. Second entry operand2=0xFFFFFFFF. out_valid stays 1 across both.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged. Assert out_ready=1 -> new entry loads on the same edge.
- instr=0x00000033 (add x0) -> reg_write=0, illegal=0. instr=0x0020C0B3 (funct3=100 via R-type, xor) -> alu_op=4. instr=0x00209033 (sll) -> alu_op=7, illegal=1, reg_write=0.
- flush=1 while out_valid=1, out_ready=0, in_valid=1 -> in_ready=0, next cycle out_valid=0, input not captured.
- Assert rst_n=0 asynchronously between edges while out_valid=1 -> out_valid=0 and alu_op=7 immediately, without waiting for clk.
